// File: rtl/net_bus_pkg.sv
// Shared types and helpers for the NetBus five-way arbiter.
package net_bus_pkg;

  localparam int NB_PORTS = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } nb_state_t;

  function automatic int NB_WIDTH(input int data_width);
    return data_width * 9 + 14;
  endfunction

endpackage

// File: rtl/net_bus_rr_pick5.sv
// Round-robin picker: first asserted request searching ptr+1, ptr+2, ... modulo 5.
module net_bus_rr_pick5
  import net_bus_pkg::*;
(
  input  logic [NB_PORTS-1:0] i_req,
  input  logic [2:0]          i_ptr,
  output logic [2:0]          o_idx,
  output logic                o_found
);

  logic [2:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    // scan farthest first so the nearest hit after the pointer overwrites the rest
    for (int k = NB_PORTS; k >= 1; k--) begin
      w_cand = 3'(({1'b0, i_ptr} + 4'(k)) % 4'd5);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/net_bus_arb5.sv
// Five-to-one NetBus arbiter with round-robin, packet-atomic grants and one output register.
// Optional mid-packet idle timeout is compiled in with NETBUS_ARB_TIMEOUT_EN.
//   state   | meaning
//   ST_IDLE | no grant; arbitrate among valid requesters (1 cycle)
//   ST_BUSY | packet granted to GNT until its last beat is accepted
module net_bus_arb5
  import net_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LAST_BIT   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NB_WIDTH(DATA_WIDTH)-1:0] RDATA0,
  input  logic [NB_WIDTH(DATA_WIDTH)-1:0] RDATA1,
  input  logic [NB_WIDTH(DATA_WIDTH)-1:0] RDATA2,
  input  logic [NB_WIDTH(DATA_WIDTH)-1:0] RDATA3,
  input  logic [NB_WIDTH(DATA_WIDTH)-1:0] RDATA4,
  input  logic                            RVALID0,
  input  logic                            RVALID1,
  input  logic                            RVALID2,
  input  logic                            RVALID3,
  input  logic                            RVALID4,
  output logic                            RREADY0,
  output logic                            RREADY1,
  output logic                            RREADY2,
  output logic                            RREADY3,
  output logic                            RREADY4,
  output logic [NB_WIDTH(DATA_WIDTH)-1:0] DATA,
  output logic                            VALID,
  input  logic                            READY,
  output logic [2:0]                      GNT,
  output logic                            BUSY,
  output logic                            ERR
);

  localparam int W = NB_WIDTH(DATA_WIDTH);

  if (LAST_BIT < 0 || LAST_BIT >= W || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("net_bus_arb5: LAST_BIT or TIMEOUT out of range");
  end

  nb_state_t           r_state;
  logic [W-1:0]        r_data;
  logic                r_valid;
  logic [2:0]          r_gnt;
  logic                r_err;

  logic [W-1:0]        w_rdata [NB_PORTS];
  logic [W-1:0]        w_rdata_g;
  logic [NB_PORTS-1:0] w_rvalid;
  logic [NB_PORTS-1:0] w_rready;
  logic [2:0]          w_pick;
  logic                w_found;
  logic                w_room;
  logic                w_rvalid_g;
  logic                w_in_xfer;

  assign w_rdata[0] = RDATA0;
  assign w_rdata[1] = RDATA1;
  assign w_rdata[2] = RDATA2;
  assign w_rdata[3] = RDATA3;
  assign w_rdata[4] = RDATA4;
  assign w_rvalid   = {RVALID4, RVALID3, RVALID2, RVALID1, RVALID0};

  assign w_rdata_g  = w_rdata[r_gnt];
  assign w_rvalid_g = w_rvalid[r_gnt];
  assign w_room     = ~r_valid | READY;
  assign w_in_xfer  = (r_state == ST_BUSY) & w_rvalid_g & w_room;

  always_comb begin
    w_rready = '0;
    if (r_state == ST_BUSY && w_room) w_rready[r_gnt] = 1'b1;
  end

  net_bus_rr_pick5 u_pick (
    .i_req   (w_rvalid),
    .i_ptr   (r_gnt),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

`ifdef NETBUS_ARB_TIMEOUT_EN
  logic [15:0] r_tcnt;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_gnt   <= 3'(NB_PORTS - 1);
      r_err   <= 1'b0;
`ifdef NETBUS_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      if (w_in_xfer) begin
        r_data  <= w_rdata_g;
        r_valid <= 1'b1;
      end else if (r_valid && READY) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
`ifdef NETBUS_ARB_TIMEOUT_EN
          r_tcnt <= '0;
`endif
          if (w_found) begin
            r_gnt   <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_xfer && w_rdata_g[LAST_BIT]) r_state <= ST_IDLE;
`ifdef NETBUS_ARB_TIMEOUT_EN
          // GNT stays on the stalled requester, so the next search starts just past it
          if (w_rvalid_g) begin
            r_tcnt <= '0;
          end else if (r_tcnt == 16'(TIMEOUT - 1)) begin
            r_tcnt  <= '0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DATA    = r_data;
  assign VALID   = r_valid;
  assign GNT     = r_gnt;
  assign BUSY    = (r_state == ST_BUSY);
  assign ERR     = r_err;
  assign RREADY0 = w_rready[0];
  assign RREADY1 = w_rready[1];
  assign RREADY2 = w_rready[2];
  assign RREADY3 = w_rready[3];
  assign RREADY4 = w_rready[4];

endmodule

// File: tb/tb_net_bus_arb5.sv
// Self-checking bench for net_bus_arb5: directed scenarios plus randomized traffic
// compared against a packet-level round-robin model.
module tb_net_bus_arb5;
  import net_bus_pkg::*;

  localparam int DW = 4;
  localparam int W  = NB_WIDTH(DW);

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         READY = 1'b1;
  logic [W-1:0] rdata [5];
  logic [4:0]   rvalid;
  logic [4:0]   rready;
  logic [W-1:0] DATA;
  logic         VALID;
  logic [2:0]   GNT;
  logic         BUSY;
  logic         ERR;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] src_q [5][$];
  logic [W-1:0] exp_q [$];
  int           npk [5];
  bit           in_pkt [5];
  int           gap [5];
  bit           acc [5];
  bit           oxfer;
  logic [W-1:0] odata;
  int           got;
  int           total;

  net_bus_arb5 #(.DATA_WIDTH(DW), .LAST_BIT(0), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .RDATA0(rdata[0]), .RDATA1(rdata[1]), .RDATA2(rdata[2]), .RDATA3(rdata[3]), .RDATA4(rdata[4]),
    .RVALID0(rvalid[0]), .RVALID1(rvalid[1]), .RVALID2(rvalid[2]), .RVALID3(rvalid[3]), .RVALID4(rvalid[4]),
    .RREADY0(rready[0]), .RREADY1(rready[1]), .RREADY2(rready[2]), .RREADY3(rready[3]), .RREADY4(rready[4]),
    .DATA(DATA), .VALID(VALID), .READY(READY), .GNT(GNT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_pos();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    rvalid = '0;
    for (int i = 0; i < 5; i++) rdata[i] = '0;
    READY = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    at_pos();
    at_pos();
    RST = 1'b0;
  endtask

  function automatic logic [W-1:0] enc(input int n, input int p, input int b, input bit last);
    return W'((n << 16) | (p << 8) | (b << 4) | (last ? 1 : 0));
  endfunction

  // Packets are generated per requester; the expected output order is plain
  // round-robin over requesters that still have packets, starting after index 4.
  function automatic void build_round(input int seed_req);
    int ptr;
    int left;
    int pick;
    int m;
    int len;
    int pi [5];
    int plen [5][$];
    exp_q.delete();
    total = 0;
    left  = 0;
    for (int n = 0; n < 5; n++) begin
      src_q[n].delete();
      plen[n].delete();
      npk[n] = $urandom_range(0, 3);
      if (n == seed_req && npk[n] == 0) npk[n] = 1;
      for (int p = 0; p < npk[n]; p++) begin
        len = $urandom_range(1, 4);
        plen[n].push_back(len);
        for (int b = 0; b < len; b++) src_q[n].push_back(enc(n, p, b, b == len - 1));
      end
      pi[n] = 0;
      left += npk[n];
    end
    ptr = 4;
    while (left > 0) begin
      pick = -1;
      for (int k = 1; k <= 5; k++) begin
        m = (ptr + k) % 5;
        if (pick < 0 && pi[m] < npk[m]) pick = m;
      end
      for (int b = 0; b < plen[pick][pi[pick]]; b++) begin
        exp_q.push_back(enc(pick, pi[pick], b, b == plen[pick][pi[pick]] - 1));
        total++;
      end
      pi[pick]++;
      ptr = pick;
      left--;
    end
  endfunction

  task automatic drive_random();
    for (int n = 0; n < 5; n++) begin
      if (src_q[n].size() > 0) begin
        rdata[n] = src_q[n][0];
        if (in_pkt[n] && gap[n] < 3 && $urandom_range(0, 3) == 0) begin
          rvalid[n] = 1'b0;
          gap[n]++;
        end else begin
          rvalid[n] = 1'b1;
          gap[n] = 0;
        end
      end else begin
        rvalid[n] = 1'b0;
        rdata[n]  = '0;
      end
    end
    READY = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    // reset state
    idle_inputs();
    RST = 1'b1;
    at_pos();
    at_neg();
    chk("rst_valid", VALID, 0);
    chk("rst_data", DATA, 0);
    chk("rst_gnt", GNT, 4);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rready", rready, 0);
    at_pos();
    RST = 1'b0;

    // single requester, 3-beat packet
    at_pos();
    rvalid[2] = 1'b1; rdata[2] = W'(32'h1000);
    at_neg();
    chk("t1_idle", BUSY, 0);
    at_pos();
    at_neg();
    chk("t1_gnt", GNT, 2);
    chk("t1_busy", BUSY, 1);
    chk("t1_rready", rready, 5'b00100);
    at_pos();
    rdata[2] = W'(32'h1002);
    at_neg();
    chk("t1_beat0", DATA, 32'h1000);
    chk("t1_valid0", VALID, 1);
    at_pos();
    rdata[2] = W'(32'h1001);
    at_neg();
    chk("t1_beat1", DATA, 32'h1002);
    at_pos();
    rvalid[2] = 1'b0;
    at_neg();
    chk("t1_beat2", DATA, 32'h1001);
    chk("t1_busy_end", BUSY, 0);
    chk("t1_valid2", VALID, 1);
    at_pos();
    at_neg();
    chk("t1_drained", VALID, 0);

    // all five requesting single-beat packets
    do_reset();
    for (int n = 0; n < 5; n++) begin
      rvalid[n] = 1'b1;
      rdata[n]  = W'((n << 8) | 1);
    end
    for (int k = 0; k < 6; k++) begin
      at_pos();
      at_neg();
      chk("t2_gnt", GNT, k % 5);
      chk("t2_busy", BUSY, 1);
      at_pos();
      at_neg();
      chk("t2_data", DATA, ((k % 5) << 8) | 1);
      chk("t2_gap_idle", BUSY, 0);
    end

    // sink stall in the middle of a 4-beat packet
    do_reset();
    rvalid[1] = 1'b1; rdata[1] = W'(32'h2010);
    at_pos();
    at_neg();
    chk("t3_gnt", GNT, 1);
    at_pos();
    rdata[1] = W'(32'h2020);
    at_neg();
    chk("t3_beat0", DATA, 32'h2010);
    at_pos();
    rdata[1] = W'(32'h2030);
    READY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) at_pos();
      at_neg();
      chk("t3_stall_data", DATA, 32'h2020);
      chk("t3_stall_valid", VALID, 1);
      chk("t3_stall_rready", rready, 0);
    end
    at_pos();
    READY = 1'b1;
    at_neg();
    chk("t3_resume_data", DATA, 32'h2020);
    chk("t3_resume_rready", rready, 5'b00010);
    at_pos();
    rdata[1] = W'(32'h2041);
    at_neg();
    chk("t3_beat2", DATA, 32'h2030);
    at_pos();
    rvalid[1] = 1'b0;
    at_neg();
    chk("t3_beat3", DATA, 32'h2041);
    chk("t3_busy_end", BUSY, 0);
    at_pos();
    at_neg();
    chk("t3_drained", VALID, 0);

    // competing request while another packet is in flight
    do_reset();
    rvalid[3] = 1'b1; rdata[3] = W'(32'h3010);
    at_pos();
    at_neg();
    chk("t4_gnt3", GNT, 3);
    at_pos();
    rdata[3] = W'(32'h3021);
    rvalid[0] = 1'b1; rdata[0] = W'(32'h0011);
    at_neg();
    chk("t4_rready0_held", rready[0], 0);
    chk("t4_beat0", DATA, 32'h3010);
    at_pos();
    rvalid[3] = 1'b0;
    at_neg();
    chk("t4_beat1", DATA, 32'h3021);
    chk("t4_idle", BUSY, 0);
    chk("t4_rready_idle", rready, 0);
    at_pos();
    at_neg();
    chk("t4_gnt0", GNT, 0);
    chk("t4_rready0", rready, 5'b00001);
    at_pos();
    rvalid[0] = 1'b0;
    at_neg();
    chk("t4_data0", DATA, 32'h0011);

    // asynchronous reset mid-packet
    do_reset();
    rvalid[1] = 1'b1; rdata[1] = W'(32'h5010);
    at_pos();
    at_neg();
    chk("t5_gnt", GNT, 1);
    at_pos();
    rdata[1] = W'(32'h5020);
    #1;
    chk("t5_pre_valid", VALID, 1);
    RST = 1'b1;
    #1;
    chk("t5_rst_valid", VALID, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_rready", rready, 0);
    chk("t5_rst_gnt", GNT, 4);
    idle_inputs();
    at_pos();
    RST = 1'b0;
    rvalid[0] = 1'b1; rdata[0] = W'(32'h0051);
    rvalid[2] = 1'b1; rdata[2] = W'(32'h2051);
    at_pos();
    at_neg();
    chk("t5_after_gnt0", GNT, 0);
    at_pos();
    rvalid[0] = 1'b0;
    at_neg();
    chk("t5_after_data", DATA, 32'h0051);

    // granted requester stops mid-packet
    do_reset();
    rvalid[2] = 1'b1; rdata[2] = W'(32'h6010);
    at_pos();
    at_neg();
    chk("t6_gnt", GNT, 2);
    at_pos();
    rvalid[2] = 1'b0;
    rvalid[3] = 1'b1; rdata[3] = W'(32'h6031);
    at_neg();
    chk("t6_beat0", DATA, 32'h6010);
`ifdef NETBUS_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        at_pos();
        at_neg();
      end
      chk("t6_err_low", ERR, 0);
      chk("t6_busy_held", BUSY, 1);
    end
    at_pos();
    at_neg();
    chk("t6_err_pulse", ERR, 1);
    chk("t6_forced_idle", BUSY, 0);
    at_pos();
    at_neg();
    chk("t6_err_once", ERR, 0);
    chk("t6_next_gnt", GNT, 3);
    at_pos();
    rvalid[3] = 1'b0;
    at_neg();
    chk("t6_next_data", DATA, 32'h6031);
`else
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        at_pos();
        at_neg();
      end
      chk("t6_err_tied", ERR, 0);
      chk("t6_busy_held", BUSY, 1);
      chk("t6_gnt_held", GNT, 2);
      chk("t6_rready3_blocked", rready[3], 0);
    end
`endif

    // randomized traffic with sink back-pressure and mid-packet source gaps
    for (int r = 0; r < 3; r++) begin
      do_reset();
      build_round(r);
      got = 0;
      for (int n = 0; n < 5; n++) begin
        in_pkt[n] = 1'b0;
        gap[n]    = 0;
      end
      for (int cyc = 0; cyc < 2000 && got < total; cyc++) begin
        drive_random();
        at_neg();
        for (int n = 0; n < 5; n++) acc[n] = rvalid[n] & rready[n];
        oxfer = VALID & READY;
        odata = DATA;
        chk("rnd_rready_onehot", $countones(rready) <= 1, 1);
        if (VALID && !READY) chk("rnd_stall_rready", rready, 0);
        at_pos();
        for (int n = 0; n < 5; n++) begin
          if (acc[n]) begin
            in_pkt[n] = !src_q[n][0][0];
            void'(src_q[n].pop_front());
          end
        end
        if (oxfer) begin
          if (exp_q.size() == 0) begin
            chk("rnd_unexpected_beat", exp_q.size(), 1);
          end else begin
            chk("rnd_beat", odata, exp_q.pop_front());
            got++;
          end
        end
      end
      chk("rnd_beat_count", got, total);
      chk("rnd_leftover", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
